// File: rtl/mux_gea0_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the N:1 handshake mux.
package mux_gea0_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef enum logic {ST_OPEN, ST_LOCK} state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb_nx1_gea0.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping modulo NCH.
module rr_arb_nx1_gea0 #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            gnt_vld_o,
    output logic [SELW-1:0] gnt_idx_o
);

    logic [2*NCH-1:0] req_dbl;
    logic [NCH-1:0]   req_rot;

    // Rotating a doubled copy puts channel ptr+1 at bit 0.
    assign req_dbl = {req_i, req_i};
    assign req_rot = NCH'(req_dbl >> (32'(ptr_i) + 32'd1));

    always_comb begin
        logic [NCH-1:0] rot_sh;
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        rot_sh    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            rot_sh = req_rot >> i;
            if (!gnt_vld_o && rot_sh[0]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = SELW'((32'(ptr_i) + 32'd1 + i) % NCH);
            end
        end
    end

endmodule

// File: rtl/mux_nchx1_hs_gea0.sv
// Registered N:1 data mux with valid/ready on every port, DIRECT or round-robin grant,
// and grant locking across multi-beat packets framed by in_last.
module mux_nchx1_hs_gea0
    import mux_gea0_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode_i,
    input  logic [SELW-1:0]    sel_i,
    input  logic [NCH-1:0]     in_valid_i,
    output logic [NCH-1:0]     in_ready_o,
    input  logic [NCH*WIDTH-1:0] in_data_i,
    input  logic [NCH-1:0]     in_last_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   out_data_o,
    output logic               out_last_o,
    output logic [SELW-1:0]    out_ch_o
);

    if (NCH < 2 || NCH > 16 || SELW < clog2(NCH)) begin : g_param_err
        $error("mux_nchx1_hs_gea0: NCH must be 2..16 and SELW >= clog2(NCH)");
    end

    state_e            state_q;
    logic [SELW-1:0]   lock_ch_q;
    logic [SELW-1:0]   ptr_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_last_q;
    logic [SELW-1:0]   out_ch_q;

    logic              rr_vld;
    logic [SELW-1:0]   rr_idx;
    logic              grant_vld;
    logic [SELW-1:0]   grant_idx;
    logic              load_ok;
    logic              xfer;
    logic [NCH-1:0]    hit;
    logic [NCH*WIDTH-1:0] data_masked;
    logic [WIDTH-1:0]  data_d;
    logic              last_d;

    rr_arb_nx1_gea0 #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arb (
        .req_i     (in_valid_i),
        .ptr_i     (ptr_q),
        .gnt_vld_o (rr_vld),
        .gnt_idx_o (rr_idx)
    );

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state_q == ST_LOCK) begin
            grant_vld = 1'b1;
            grant_idx = lock_ch_q;
        end else if (mode_i == MODE_RR) begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end else if (32'(sel_i) < NCH) begin
            grant_vld = 1'b1;
            grant_idx = sel_i;
        end
    end

    assign load_ok = !out_valid_q || out_ready_i;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign hit[k] = grant_vld && (grant_idx == SELW'(k));
        // Reset gating keeps every channel stalled while the block is held in reset.
        assign in_ready_o[k] = rst_n && load_ok && hit[k];
        assign data_masked[k*WIDTH +: WIDTH] = {WIDTH{hit[k]}} & in_data_i[k*WIDTH +: WIDTH];
    end

    always_comb begin
        data_d = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            data_d = data_d | WIDTH'(data_masked >> (k * WIDTH));
        end
    end

    assign last_d = |(hit & in_last_i);
    assign xfer   = |(in_valid_i & in_ready_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OPEN;
            lock_ch_q   <= '0;
            ptr_q       <= SELW'(NCH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= data_d;
                out_last_q  <= last_d;
                out_ch_q    <= grant_idx;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (xfer) begin
                if (last_d) begin
                    state_q <= ST_OPEN;
                    ptr_q   <= grant_idx;
                end else if (state_q == ST_OPEN) begin
                    state_q   <= ST_LOCK;
                    lock_ch_q <= grant_idx;
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_mux_nchx1_hs_gea0.sv
// Directed bench for the N:1 handshake mux with a packet-level reference model checked every cycle.
module tb_mux_nchx1_hs_gea0;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [2:0]  sel;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [2:0]  out_ch;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state (m_*) and next state computed each cycle (n_*).
    int          m_ptr = NCH - 1, n_ptr = NCH - 1;
    bit          m_lock = 0, n_lock = 0;
    int          m_lch = 0, n_lch = 0;
    bit          m_ov = 0, n_ov = 0;
    logic [7:0]  m_od = 8'h00, n_od = 8'h00;
    bit          m_ol = 0, n_ol = 0;
    int          m_och = 0, n_och = 0;

    always #5 clk = ~clk;

    mux_nchx1_hs_gea0 #(
        .WIDTH (8),
        .NCH   (4),
        .SELW  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_i      (mode),
        .sel_i       (sel),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_ch_o    (out_ch)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int k, input logic [7:0] v);
        in_data[k*8 +: 8] = v;
    endtask

    always @(negedge rst_n) begin
        m_ptr = NCH - 1; m_lock = 0; m_lch = 0; m_ov = 0; m_od = 8'h00; m_ol = 0; m_och = 0;
        n_ptr = NCH - 1; n_lock = 0; n_lch = 0; n_ov = 0; n_od = 8'h00; n_ol = 0; n_och = 0;
    end

    always @(negedge clk) begin
        int g;
        logic [3:0] er;
        g  = -1;
        er = 4'b0000;
        if (rst_n === 1'b1) begin
            if (m_lock) g = m_lch;
            else if (mode === 1'b1) begin
                for (int i = 1; i <= NCH; i++) begin
                    int k;
                    k = (m_ptr + i) % NCH;
                    if (g < 0 && in_valid[k]) g = k;
                end
            end else if (int'(sel) < NCH) g = int'(sel);
            if (g >= 0 && (!m_ov || out_ready)) er[g] = 1'b1;
        end
        chk("mdl_in_ready", 32'(in_ready), 32'(er));
        chk("mdl_out_valid", 32'(out_valid), 32'(m_ov));
        chk("mdl_out_data", 32'(out_data), 32'(m_od));
        chk("mdl_out_last", 32'(out_last), 32'(m_ol));
        chk("mdl_out_ch", 32'(out_ch), 32'(m_och));
        n_ptr = m_ptr; n_lock = m_lock; n_lch = m_lch;
        n_ov = m_ov; n_od = m_od; n_ol = m_ol; n_och = m_och;
        if (er != 4'b0000 && in_valid[g]) begin
            n_ov  = 1;
            n_od  = in_data[g*8 +: 8];
            n_ol  = in_last[g];
            n_och = g;
            if (in_last[g]) begin
                n_lock = 0;
                n_ptr  = g;
            end else if (!m_lock) begin
                n_lock = 1;
                n_lch  = g;
            end
        end else if (out_ready) begin
            n_ov = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            m_ptr = n_ptr; m_lock = n_lock; m_lch = n_lch;
            m_ov = n_ov; m_od = n_od; m_ol = n_ol; m_och = n_och;
        end
    end

    initial begin
        // T1: reset with every channel requesting
        rst_n = 1'b0; mode = 1'b1; sel = 3'd0; out_ready = 1'b1;
        in_valid = 4'b1111; in_last = 4'b1111; in_data = 32'h13121110;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_first_grant", 32'(in_ready), 32'h1);
        // T3: round-robin fairness, single-beat packets
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_out_ch", 32'(out_ch), 32'(i % 4));
            chk("rr_out_data", 32'(out_data), 32'h10 + 32'(i % 4));
        end

        // T2: DIRECT select, then out-of-range select
        mode = 1'b0; sel = 3'd2; in_valid = 4'b0100; set_d(2, 8'h5A);
        @(negedge clk);
        chk("dir_in_ready", 32'(in_ready), 32'h4);
        tick();
        chk("dir_out_data", 32'(out_data), 32'h5A);
        chk("dir_out_ch", 32'(out_ch), 32'd2);
        chk("dir_out_last", 32'(out_last), 32'd1);
        sel = 3'd5; in_valid = 4'b1111;
        @(negedge clk);
        chk("dir_sel_oob_ready", 32'(in_ready), 32'd0);
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_out_data_hold", 32'(out_data), 32'h5A);

        // T4: ch1 three-beat packet, sel toggling, then RR picks ch2
        sel = 3'd1; in_valid = 4'b0111; in_last = 4'b0101; in_data = 32'h1312A110;
        tick();
        chk("lock_b1_ch", 32'(out_ch), 32'd1);
        chk("lock_b1_data", 32'(out_data), 32'hA1);
        chk("lock_b1_last", 32'(out_last), 32'd0);
        sel = 3'd0; set_d(1, 8'hA2);
        @(negedge clk);
        chk("lock_in_ready", 32'(in_ready), 32'h2);
        tick();
        chk("lock_b2_ch", 32'(out_ch), 32'd1);
        chk("lock_b2_data", 32'(out_data), 32'hA2);
        sel = 3'd2; set_d(1, 8'hA3); in_last = 4'b0111;
        tick();
        chk("lock_b3_ch", 32'(out_ch), 32'd1);
        chk("lock_b3_data", 32'(out_data), 32'hA3);
        chk("lock_b3_last", 32'(out_last), 32'd1);
        mode = 1'b1;
        tick();
        chk("post_lock_ch", 32'(out_ch), 32'd2);
        chk("post_lock_data", 32'(out_data), 32'h12);

        // T5: four cycles of backpressure, then resume
        in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'h12);
            chk("bp_out_ch", 32'(out_ch), 32'd2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_resume_ch3", 32'(out_ch), 32'd3);
        chk("bp_resume_d3", 32'(out_data), 32'h13);
        tick();
        chk("bp_resume_ch0", 32'(out_ch), 32'd0);
        tick();
        chk("bp_resume_ch1", 32'(out_ch), 32'd1);
        chk("bp_resume_d1", 32'(out_data), 32'hA3);

        // T6: reset in the middle of a ch3 packet
        mode = 1'b0; sel = 3'd3; in_valid = 4'b1000; in_last = 4'b0000; set_d(3, 8'hC1);
        tick();
        chk("mid_b1_ch", 32'(out_ch), 32'd3);
        chk("mid_b1_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1; mode = 1'b1; in_valid = 4'b1001; in_last = 4'b1111;
        @(negedge clk);
        chk("mid_rel_grant", 32'(in_ready), 32'h1);
        tick();
        chk("mid_rel_ch", 32'(out_ch), 32'd0);
        chk("mid_rel_data", 32'(out_data), 32'h10);

        in_valid = 4'b0000;
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
